serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
Downstream consumer of the 4-bit bidirectional shift register's serial output stream. It hunts for a start bit and collects WIDTH data bits, either LSB-first or MSB-first. It presents the assembled word on a single-entry valid/ready output buffer and flags overruns. It sits between the shift-register stage and any parallel consumer, such as a register file or display.

Parameters:
WIDTH, 4, data bits per frame (legal range 2..16)
CNT_W, 4, counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
bit_valid  input  1  qualifies bit_in this cycle; low = stall, bit ignored
bit_in  input  1  serial data bit
dir  input  1  0 = LSB-first (right-shift source), 1 = MSB-first (left-shift source); sampled with start bit
out_data  output  WIDTH  assembled frame word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid && out_ready
overrun  output  1  one-cycle pulse: completed frame dropped
parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped (tied 0 without macro)
busy  output  1  high while state != IDLE

Behaviour:
- Reset (rst=1, async) forces all of the following at once: state=IDLE; out_data=0; out_valid=0; overrun=0; parity_err=0; busy=0; bit counter=0; shift register=0; latched dir=0.
- Reset mid-frame discards the partial frame; the held output word is lost.
- States: IDLE, DATA, PARITY (only with macro). The output buffer is a separate flag (out_valid), not an FSM state.
- IDLE: a cycle with bit_valid=1 and bit_in=1 is the start bit → DATA; the same cycle sets cnt=0 and latches dir. A cycle with bit_valid=1 and bit_in=0 stays in IDLE (line idle). bit_valid=0 is ignored.
- DATA: each bit_valid=1 cycle shifts in one bit and increments cnt. bit_valid=0 holds all state.
  - dir=0: first data bit lands in out_data[0]; the shift register shifts right, new bit at MSB.
  - dir=1: first data bit lands in out_data[WIDTH-1]; the shift register shifts left, new bit at LSB.
- Frame completion is the cycle the WIDTH-th data bit is accepted (or the parity bit, with macro). State returns to IDLE that same edge. A start bit is accepted on the very next cycle (back-to-back frames, no gap required).
- Latency: out_valid rises on the clock edge that accepts the last bit, i.e. it is visible the cycle after the last bit is presented.
- Output buffer at completion:
  - out_valid=0: load out_data; out_valid=1.
  - out_valid=1 and out_ready=1 the same cycle: old word is consumed, new word is loaded, out_valid stays 1.
  - out_valid=1 and out_ready=0: new word is dropped, out_data unchanged, overrun=1 for exactly one cycle.
- Handshake: the word transfers on any cycle with out_valid && out_ready. With no completion that cycle, out_valid→0 next cycle and out_data holds its value. out_data is stable while out_valid=1 && out_ready=0.
- dir changes mid-frame have no effect; only the value latched with the start bit is used.
- busy = (state != IDLE); it is registered state decode, not combinational from inputs.

Optional Feature:
Macro RX_PARITY_CHECK_EN.
- Defined: after the WIDTH data bits, DATA → PARITY. The next bit_valid bit is an even-parity bit, so the XOR of the data bits and the parity bit must be 0.
  - Match: normal completion rules apply.
  - Mismatch: frame dropped, parity_err=1 for one cycle, output buffer untouched, return to IDLE.
  - Overrun is evaluated only for frames with good parity.
- Undefined: no PARITY state; frames are WIDTH data bits only; parity_err is a constant 0 and the port remains.

Decomposition:
- Shared package sr_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_DATA=2'd1, ST_PARITY=2'd2;
  - DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1;
  - the default WIDTH, shared with the shift-register stage.
- One natural sub-module, rx_shift_core: the shift register plus bit counter with a dir-controlled shift direction and a done strobe. The FSM and output buffer stay in the top.

Test Plan:
1. WIDTH=4, dir=0; stream start=1, data 1,0,1,1 all with bit_valid=1; out_ready=1 → out_data=4'b1101, out_valid high one cycle after the last bit, then low.
2. Same bits with dir=1 → out_data=4'b1011. Toggling dir mid-frame → result unchanged.
3. Frame A 0,0,1,0 (dir=0) → 4'h4 held with out_ready=0. Frame B 1,1,1,1 completes → overrun pulses once, out_data stays 4'h4. Then raise out_ready → 4'h4 is accepted, out_valid=0.
4. Idle zeros and bit_valid=0 gaps inserted randomly between data bits → same word as without gaps. Back-to-back frames with no idle bit → both words received in order.
5. rst asserted asynchronously after 2 data bits → all outputs 0 immediately. The next clean frame 1,1,0,0 (dir=0) → 4'h3.
6. With RX_PARITY_CHECK_EN: data 1,0,1,1 with parity 1 → 4'hD accepted. Same data with parity 0 → parity_err pulse, no out_valid.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register stage and its frame receiver.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Frame width shared with the upstream 4-bit shift register.
    localparam int unsigned SR_WIDTH = 4;

endpackage

// File: rtl/rx_shift_core.sv
// Deserialising shift register and bit counter for serial_frame_receiver.
// Direction is latched on start; done strobes while the last data bit is accepted.
module rx_shift_core
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = SR_WIDTH,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;

    // word includes the bit accepted this cycle, so the top can load it on the same edge.
    always_comb begin
        shifted = '0;
        if (dir_q == DIR_MSB_FIRST) begin
            shifted = {sr[WIDTH-2:0], bit_in};
        end else begin
            shifted = {bit_in, sr[WIDTH-1:1]};
        end
        word = shift_en ? shifted : sr;
        done = shift_en && (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (start) begin
            sr    <= '0;
            cnt   <= '0;
            dir_q <= dir;
        end else if (shift_en) begin
            sr    <= shifted;
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start-bit hunt, WIDTH-bit LSB/MSB-first capture, single-entry output buffer.
// Optional even-parity check enabled by defining RX_PARITY_CHECK_EN.
module serial_frame_receiver
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH = SR_WIDTH,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy
);

    state_t           state;
    logic             start;
    logic             shift_en;
    logic             done;
    logic             complete;
    logic [WIDTH-1:0] word;
`ifdef RX_PARITY_CHECK_EN
    logic             par_bad;
`endif

    rx_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .shift_en (shift_en),
        .bit_in   (bit_in),
        .word     (word),
        .done     (done)
    );

    always_comb begin
        start    = (state == ST_IDLE) && bit_valid && bit_in;
        shift_en = (state == ST_DATA) && bit_valid;
`ifdef RX_PARITY_CHECK_EN
        // Even parity: XOR over data and parity bit must be zero.
        complete = (state == ST_PARITY) && bit_valid && !(^word ^ bit_in);
        par_bad  = (state == ST_PARITY) && bit_valid &&  (^word ^ bit_in);
`else
        complete = done;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_err <= par_bad;
`endif
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A same-cycle consume frees the buffer for the new word.
            if (complete) begin
                if (!out_valid || out_ready) begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_DATA;
                        busy  <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (done) begin
`ifdef RX_PARITY_CHECK_EN
                        state <= ST_PARITY;
`else
                        state <= ST_IDLE;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef RX_PARITY_CHECK_EN
                ST_PARITY: begin
                    if (bit_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef RX_PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver: directed scenarios plus randomized frames
// compared against a bit-placement model of the frame format.
module tb_serial_frame_receiver;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_valid;
    logic         bit_in;
    logic         dir;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         parity_err;
    logic         busy;

    int unsigned total  = 0;
    int unsigned passed = 0;

    serial_frame_receiver #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .dir        (dir),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of serial input; returns 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
    endtask

    // bits[i] is the i-th transmitted data bit.
    function automatic logic [W-1:0] model_word(input logic d, input logic [W-1:0] bits);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (d) w[int'(W) - 1 - i] = bits[i];
            else   w[i] = bits[i];
        end
        return w;
    endfunction

    task automatic send_frame(input logic d, input logic [W-1:0] bits, input logic gaps,
                              input logic toggle_dir);
        dir = d;
        cyc(1'b1, 1'b1);
        for (int i = 0; i < int'(W); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)));
            end
            if (toggle_dir) dir = ~dir;
            cyc(1'b1, bits[i]);
        end
`ifdef RX_PARITY_CHECK_EN
        if (gaps) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom_range(0, 1)));
        end
        cyc(1'b1, ^bits);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] bits;
        logic         d;

        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        dir       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   32'(out_valid),  32'd0);
        check("rst_data",    32'(out_data),   32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_overrun", 32'(overrun),    32'd0);
        check("rst_parerr",  32'(parity_err), 32'd0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        // LSB-first 1,0,1,1 -> 4'b1101
        dir = 1'b0;
        cyc(1'b1, 1'b1);
        check("t1_busy_start", 32'(busy), 32'd1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        check("t1_not_early", 32'(out_valid), 32'd0);
        cyc(1'b1, 1'b1);
`ifdef RX_PARITY_CHECK_EN
        cyc(1'b1, 1'b1);
`endif
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(out_data),  32'hD);
        check("t1_busy_end", 32'(busy), 32'd0);
        cyc(1'b1, 1'b0);
        check("t1_valid_drop", 32'(out_valid), 32'd0);
        check("t1_data_hold",  32'(out_data),  32'hD);

        // MSB-first, then with dir toggled mid-frame
        send_frame(1'b1, 4'b1101, 1'b0, 1'b0);
        check("t2_msb_data", 32'(out_data), 32'hB);
        send_frame(1'b1, 4'b1101, 1'b0, 1'b1);
        check("t2_toggle_valid", 32'(out_valid), 32'd1);
        check("t2_toggle_data",  32'(out_data),  32'hB);
        cyc(1'b0, 1'b0);

        // Overrun: hold frame A, drop frame B
        out_ready = 1'b0;
        send_frame(1'b0, 4'b0100, 1'b0, 1'b0);
        check("t3_a_valid",   32'(out_valid), 32'd1);
        check("t3_a_data",    32'(out_data),  32'h4);
        check("t3_a_overrun", 32'(overrun),   32'd0);
        send_frame(1'b0, 4'b1111, 1'b0, 1'b0);
        check("t3_b_overrun", 32'(overrun),   32'd1);
        check("t3_b_data",    32'(out_data),  32'h4);
        cyc(1'b0, 1'b0);
        check("t3_overrun_pulse", 32'(overrun),   32'd0);
        check("t3_still_valid",   32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cyc(1'b0, 1'b0);
        check("t3_accepted", 32'(out_valid), 32'd0);
        check("t3_hold",     32'(out_data),  32'h4);

        // Random frames with idle zeros, stalls and back-to-back starts
        for (int n = 0; n < 30; n++) begin
            d    = 1'($urandom_range(0, 1));
            bits = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)), 1'b0);
            end
            send_frame(d, bits, 1'b1, 1'($urandom_range(0, 1)));
            check($sformatf("t4_valid_%0d", n), 32'(out_valid), 32'd1);
            check($sformatf("t4_data_%0d", n),  32'(out_data),  32'(model_word(d, bits)));
        end
        cyc(1'b0, 1'b0);

        // Asynchronous reset mid-frame with a word held
        out_ready = 1'b0;
        send_frame(1'b0, 4'b1010, 1'b0, 1'b0);
        check("t5_held", 32'(out_data), 32'hA);
        dir = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_data",  32'(out_data),  32'd0);
        check("t5_rst_busy",  32'(busy),      32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_frame(1'b0, 4'b0011, 1'b0, 1'b0);
        check("t5_clean_valid", 32'(out_valid), 32'd1);
        check("t5_clean_data",  32'(out_data),  32'h3);
        cyc(1'b0, 1'b0);

`ifdef RX_PARITY_CHECK_EN
        send_frame(1'b0, 4'b1101, 1'b0, 1'b0);
        check("t6_good_data",   32'(out_data),   32'hD);
        check("t6_good_parerr", 32'(parity_err), 32'd0);
        cyc(1'b0, 1'b0);
        dir = 1'b0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("t6_bad_parerr", 32'(parity_err), 32'd1);
        check("t6_bad_valid",  32'(out_valid),  32'd0);
        check("t6_bad_busy",   32'(busy),       32'd0);
        cyc(1'b0, 1'b0);
        check("t6_parerr_pulse", 32'(parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
